multi_core_nonce_scheduler: RTL and testbench
=============================================

Name: multi_core_nonce_scheduler

Overview:
Parametrised successor to the single-engine block solver. It accepts one mining job (midstate, header leftovers, target, inclusive nonce range) and splits the range across NUM_CORES external SHA-256d hash cores with a fixed stride. It collects the tagged results, compares each against the target, and reports FOUND or EXHAUSTED using the existing state_out encoding. It supports stop-on-first or full-range solution counting, abort, and safe handling of a range that ends at 0xFFFFFFFF.

Parameters:
NUM_CORES, 4, number of hash cores; core i owns nonces start+i, start+i+NUM_CORES, ...
NONCE_W, 32, nonce width
MAX_OUTST, 16, maximum in-flight requests per core; sizes each outstanding counter
STOP_ON_FIRST, 1, 1 = stop issuing and drain at first solution; 0 = scan the full range and count solutions

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job offer
job_ready  out  1  high in IDLE, FOUND, EXHAUSTED
midstate  in  256  job midstate, latched on accept
header_leftovers  in  96  last header word bits, latched on accept
target  in  256  unsigned threshold, latched on accept
nonce_start  in  NONCE_W  first nonce, inclusive
nonce_end  in  NONCE_W  last nonce, inclusive
abort  in  1  abandon current job
core_req_valid  out  NUM_CORES  per-core request valid
core_req_ready  in  NUM_CORES  per-core request ready
core_nonce  out  NUM_CORES*NONCE_W  per-core nonce; core i at [i*NONCE_W +: NONCE_W]
core_midstate  out  256  latched midstate, shared by all cores
core_leftovers  out  96  latched leftovers, shared by all cores
core_res_valid  in  NUM_CORES  per-core result strobe; no backpressure
core_res_hash  in  NUM_CORES*256  per-core result hash
core_res_nonce  in  NUM_CORES*NONCE_W  nonce tag for each result
state_out  out  3  0 IDLE, 1 RUN, 2 FOUND, 3 EXHAUSTED, 4 DRAIN
current_nonce  out  NONCE_W  lowest not-yet-issued nonce across cores
found_nonce  out  NONCE_W  first solution's nonce
found_hash  out  256  first solution's hash
solutions_count  out  16  solutions in this job; saturates at 0xFFFF

Behaviour:
- Reset: all outputs and state clear to 0, except job_ready, which is 1. Clock and reset polarity as decided: one clock, asynchronous active-low rst_n.
- Job accept: job_valid && job_ready. Latch the job inputs, clear found_*/solutions_count, set each core counter ctr_i = {1'b0,nonce_start}+i (NONCE_W+1 bits), go to RUN next cycle.
- Empty range: if nonce_start > nonce_end at accept, go directly to EXHAUSTED. No core_req_valid is ever asserted.
- Issue (RUN only):
  - core_req_valid[i] = (ctr_i <= nonce_end) && outst_i < MAX_OUTST.
  - core_nonce_i = ctr_i[NONCE_W-1:0].
  - On valid&ready: ctr_i += NUM_CORES and outst_i++.
  - The extra counter bit prevents wrap past 0xFFFFFFFF.
- Result: on core_res_valid[i], decrement outst_i. If outst_i is already 0, the result is ignored entirely.
- Solution test: hash <= target, unsigned, bit 255 is MSB.
  - Each solution increments solutions_count by one.
  - When several cores report solutions in one cycle, add all of them; found_* takes the lowest core index.
  - found_* is written only by the first solution of the job.
  - Results arriving in DRAIN are still counted when STOP_ON_FIRST=0. They are discarded when STOP_ON_FIRST=1 and the drain was caused by a solution.
- Transitions:
  - RUN -> DRAIN: on the first solution (STOP_ON_FIRST=1), or when every core's ctr_i > nonce_end, or on abort. Issue stops in the same cycle the condition is registered.
  - DRAIN -> next state, once all outst_i == 0:
    - abort seen: IDLE
    - else solutions_count > 0: FOUND
    - else: EXHAUSTED
  - FOUND/EXHAUSTED hold until the next job accept. Outputs stay stable while held.
- Abort: ignored in IDLE/FOUND/EXHAUSTED. In DRAIN it marks the job aborted.
- Reset mid-operation clears everything immediately. The cores are reset from the same rst_n.
- current_nonce: min over unfinished ctr_i, truncated to NONCE_W bits. Once all cores are finished it equals nonce_end.
- Latency: first core_req_valid appears 1 cycle after accept. A solution arriving in cycle N gives state_out=FOUND at N+1 when all outst_i are 0.

Test Plan:
- Bench model: per core, fixed 8-cycle latency, always ready. Returns hash=target for nonce 0x9c9a4fc0 and 256'hFF..FF otherwise. Job: midstate 256'h4a03aeb2bcf3ad77d705828c4ec62fa2282784a285936a72c71636a4ddef7254, leftovers 96'h15274c646c51f957c4400418.
- Range 0x9c9a4f00..0x9c9a4fff -> FOUND; found_nonce=0x9c9a4fc0, found_hash=target, solutions_count=1; no core_req_valid after the solution cycle; all outst drained.
- Range 0xfffffff0..0xffffffff, no solution -> EXHAUSTED after exactly 16 accepted requests (4 per core); no nonce 0x00000000 issued; current_nonce=0xffffffff.
- Range start=5, end=4 -> EXHAUSTED one cycle after accept; core_req_valid stays 0; job_ready=1.
- STOP_ON_FIRST=0, range 0..0x3f, model solutions at 0x10 (core 0) and 0x13 (core 3), returned in the same cycle -> FOUND, solutions_count=2, found_nonce=0x10.
- Threshold boundary: hash==target -> counted as a solution; hash==target+1 -> not counted (solutions_count=0, EXHAUSTED).
- Hold core 2 ready low, assert abort mid-RUN -> DRAIN until outstanding results return, then IDLE, job_ready=1. A new job is then accepted and solves normally.

Source files
------------

// File: rtl/multi_core_nonce_scheduler.sv
// Multi-core nonce scheduler: splits one mining job's inclusive nonce range
// across NUM_CORES external SHA-256d cores with a fixed stride, tracks in-flight
// requests per core, tests returned hashes against the target and reports
// FOUND / EXHAUSTED on state_out.
module multi_core_nonce_scheduler #(
  parameter int NUM_CORES     = 4,
  parameter int NONCE_W       = 32,
  parameter int MAX_OUTST     = 16,
  parameter int STOP_ON_FIRST = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [255:0]                   midstate,
  input  logic [95:0]                    header_leftovers,
  input  logic [255:0]                   target,
  input  logic [NONCE_W-1:0]             nonce_start,
  input  logic [NONCE_W-1:0]             nonce_end,
  input  logic                           abort,
  output logic [NUM_CORES-1:0]           core_req_valid,
  input  logic [NUM_CORES-1:0]           core_req_ready,
  output logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  output logic [255:0]                   core_midstate,
  output logic [95:0]                    core_leftovers,
  input  logic [NUM_CORES-1:0]           core_res_valid,
  input  logic [NUM_CORES*256-1:0]       core_res_hash,
  input  logic [NUM_CORES*NONCE_W-1:0]   core_res_nonce,
  output logic [2:0]                     state_out,
  output logic [NONCE_W-1:0]             current_nonce,
  output logic [NONCE_W-1:0]             found_nonce,
  output logic [255:0]                   found_hash,
  output logic [15:0]                    solutions_count
);

  // One extra counter bit so a counter stepping past the all-ones nonce
  // lands above nonce_end instead of wrapping back to zero.
  localparam int CTR_W = NONCE_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int CNT_W = 16;
  localparam bit STOP_MODE = (STOP_ON_FIRST != 0);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_FOUND     = 3'd2,
    ST_EXHAUSTED = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [255:0]         midstate_q, midstate_d;
  logic [95:0]          leftovers_q, leftovers_d;
  logic [255:0]         target_q, target_d;
  logic [NONCE_W-1:0]   nonce_end_q, nonce_end_d;
  logic [CTR_W-1:0]     ctr_q [NUM_CORES];
  logic [CTR_W-1:0]     ctr_d [NUM_CORES];
  logic [OUT_W-1:0]     outst_q [NUM_CORES];
  logic [OUT_W-1:0]     outst_d [NUM_CORES];
  logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
  logic [255:0]         found_hash_q, found_hash_d;
  logic [CNT_W-1:0]     sol_cnt_q, sol_cnt_d;
  logic                 found_seen_q, found_seen_d;
  logic                 aborted_q, aborted_d;
  logic                 sol_drain_q, sol_drain_d;
  logic [NUM_CORES-1:0] req_valid_q, req_valid_d;
  logic [NONCE_W-1:0]   cur_nonce_q, cur_nonce_d;
  logic                 job_ready_q, job_ready_d;

  logic [NUM_CORES-1:0] issue_s;
  logic [NUM_CORES-1:0] res_ok_s;
  logic [NUM_CORES-1:0] res_sol_s;
  logic                 count_en_s;
  logic [CNT_W:0]       sol_sum_s;
  logic                 any_sol_s;
  logic                 picked_s;
  logic [NONCE_W-1:0]   pick_nonce_s;
  logic [255:0]         pick_hash_s;
  logic                 all_idle_s;
  logic                 all_done_s;
  state_e               fin_s;
  logic [CTR_W-1:0]     cur_min_s;
  logic                 cur_any_s;

  // Per-core handshake, accepted-result and solution qualifiers.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign issue_s[g]   = req_valid_q[g] & core_req_ready[g];
    assign res_ok_s[g]  = core_res_valid[g] & (outst_q[g] != {OUT_W{1'b0}});
    assign res_sol_s[g] = res_ok_s[g] & (core_res_hash[g*256 +: 256] <= target_q);
    assign core_nonce[g*NONCE_W +: NONCE_W] = ctr_q[g][NONCE_W-1:0];
  end

  // Next-state computation: counters, in-flight tracking, solutions, FSM, outputs.
  always_comb begin
    state_d       = state_q;
    midstate_d    = midstate_q;
    leftovers_d   = leftovers_q;
    target_d      = target_q;
    nonce_end_d   = nonce_end_q;
    ctr_d         = ctr_q;
    outst_d       = outst_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    found_seen_d  = found_seen_q;
    sol_drain_d   = sol_drain_q;
    sol_sum_s     = {1'b0, sol_cnt_q};
    any_sol_s     = 1'b0;
    picked_s      = 1'b0;
    pick_nonce_s  = {NONCE_W{1'b0}};
    pick_hash_s   = {256{1'b0}};
    all_idle_s    = 1'b1;
    all_done_s    = 1'b1;
    cur_min_s     = {CTR_W{1'b1}};
    cur_any_s     = 1'b0;
    req_valid_d   = {NUM_CORES{1'b0}};

    // After a stop-on-first drain, late results are dropped.
    count_en_s = (state_q == ST_RUN) ||
                 ((state_q == ST_DRAIN) && !(STOP_MODE && sol_drain_q));

    for (int i = 0; i < NUM_CORES; i++) begin
      if (issue_s[i] && !res_ok_s[i]) begin
        outst_d[i] = outst_q[i] + OUT_W'(1);
      end else if (!issue_s[i] && res_ok_s[i]) begin
        outst_d[i] = outst_q[i] - OUT_W'(1);
      end else begin
        outst_d[i] = outst_q[i];
      end
      if (issue_s[i]) begin
        ctr_d[i] = ctr_q[i] + CTR_W'(NUM_CORES);
      end else begin
        ctr_d[i] = ctr_q[i];
      end
      // Lowest core index wins the found_* capture.
      if (res_sol_s[i] && count_en_s) begin
        sol_sum_s = sol_sum_s + (CNT_W+1)'(1);
        any_sol_s = 1'b1;
        if (!picked_s) begin
          picked_s     = 1'b1;
          pick_nonce_s = core_res_nonce[i*NONCE_W +: NONCE_W];
          pick_hash_s  = core_res_hash[i*256 +: 256];
        end else begin
          picked_s     = 1'b1;
        end
      end else begin
        any_sol_s = any_sol_s;
      end
      if (outst_d[i] != {OUT_W{1'b0}}) begin
        all_idle_s = 1'b0;
      end else begin
        all_idle_s = all_idle_s;
      end
      if (ctr_q[i] <= {1'b0, nonce_end_q}) begin
        all_done_s = 1'b0;
      end else begin
        all_done_s = all_done_s;
      end
    end

    if (sol_sum_s[CNT_W]) begin
      sol_cnt_d = 16'hFFFF;
    end else begin
      sol_cnt_d = sol_sum_s[CNT_W-1:0];
    end

    if (any_sol_s && !found_seen_q) begin
      found_seen_d  = 1'b1;
      found_nonce_d = pick_nonce_s;
      found_hash_d  = pick_hash_s;
    end else begin
      found_seen_d  = found_seen_q;
    end

    aborted_d = aborted_q | (abort & ((state_q == ST_RUN) || (state_q == ST_DRAIN)));

    if (aborted_d) begin
      fin_s = ST_IDLE;
    end else if (sol_cnt_d != {CNT_W{1'b0}}) begin
      fin_s = ST_FOUND;
    end else begin
      fin_s = ST_EXHAUSTED;
    end

    case (state_q)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
        if (job_valid) begin
          midstate_d    = midstate;
          leftovers_d   = header_leftovers;
          target_d      = target;
          nonce_end_d   = nonce_end;
          for (int i = 0; i < NUM_CORES; i++) begin
            ctr_d[i]   = {1'b0, nonce_start} + CTR_W'(i);
            outst_d[i] = {OUT_W{1'b0}};
          end
          found_nonce_d = {NONCE_W{1'b0}};
          found_hash_d  = {256{1'b0}};
          sol_cnt_d     = {CNT_W{1'b0}};
          found_seen_d  = 1'b0;
          aborted_d     = 1'b0;
          sol_drain_d   = 1'b0;
          state_d       = (nonce_start > nonce_end) ? ST_EXHAUSTED : ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (STOP_MODE && any_sol_s) begin
          sol_drain_d = 1'b1;
        end else begin
          sol_drain_d = sol_drain_q;
        end
        if (abort || (STOP_MODE && any_sol_s) || all_done_s) begin
          state_d = all_idle_s ? fin_s : ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (all_idle_s) begin
          state_d = fin_s;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs are computed from the next-state values.
    for (int i = 0; i < NUM_CORES; i++) begin
      req_valid_d[i] = (state_d == ST_RUN) &&
                       (ctr_d[i] <= {1'b0, nonce_end_d}) &&
                       (outst_d[i] < OUT_W'(MAX_OUTST));
      if ((ctr_d[i] <= {1'b0, nonce_end_d}) && (ctr_d[i] < cur_min_s)) begin
        cur_min_s = ctr_d[i];
        cur_any_s = 1'b1;
      end else begin
        cur_any_s = cur_any_s;
      end
    end
    cur_nonce_d = cur_any_s ? cur_min_s[NONCE_W-1:0] : nonce_end_d;
    job_ready_d = (state_d == ST_IDLE) || (state_d == ST_FOUND) || (state_d == ST_EXHAUSTED);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      midstate_q    <= {256{1'b0}};
      leftovers_q   <= {96{1'b0}};
      target_q      <= {256{1'b0}};
      nonce_end_q   <= {NONCE_W{1'b0}};
      for (int i = 0; i < NUM_CORES; i++) begin
        ctr_q[i]   <= {CTR_W{1'b0}};
        outst_q[i] <= {OUT_W{1'b0}};
      end
      found_nonce_q <= {NONCE_W{1'b0}};
      found_hash_q  <= {256{1'b0}};
      sol_cnt_q     <= {CNT_W{1'b0}};
      found_seen_q  <= 1'b0;
      aborted_q     <= 1'b0;
      sol_drain_q   <= 1'b0;
      req_valid_q   <= {NUM_CORES{1'b0}};
      cur_nonce_q   <= {NONCE_W{1'b0}};
      job_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      midstate_q    <= midstate_d;
      leftovers_q   <= leftovers_d;
      target_q      <= target_d;
      nonce_end_q   <= nonce_end_d;
      ctr_q         <= ctr_d;
      outst_q       <= outst_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      sol_cnt_q     <= sol_cnt_d;
      found_seen_q  <= found_seen_d;
      aborted_q     <= aborted_d;
      sol_drain_q   <= sol_drain_d;
      req_valid_q   <= req_valid_d;
      cur_nonce_q   <= cur_nonce_d;
      job_ready_q   <= job_ready_d;
    end
  end

  assign job_ready       = job_ready_q;
  assign core_req_valid  = req_valid_q;
  assign core_midstate   = midstate_q;
  assign core_leftovers  = leftovers_q;
  assign state_out       = state_q;
  assign current_nonce   = cur_nonce_q;
  assign found_nonce     = found_nonce_q;
  assign found_hash      = found_hash_q;
  assign solutions_count = sol_cnt_q;

endmodule

// File: tb/tb_multi_core_nonce_scheduler.sv
// Directed bench: two schedulers (stop-on-first and full-scan) driven by an
// 8-cycle fixed-latency, always-ready core model per core.
module tb_multi_core_nonce_scheduler;

  localparam int NC = 4;
  localparam logic [255:0] MID  = 256'h4a03aeb2bcf3ad77d705828c4ec62fa2282784a285936a72c71636a4ddef7254;
  localparam logic [95:0]  LEFT = 96'h15274c646c51f957c4400418;
  localparam logic [255:0] TGT  = 256'h00000000_0000ffff_00000000_00000000_00000000_00000000_00000000_00000000;
  localparam logic [255:0] ONES = {256{1'b1}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              job_valid [2];
  logic              abort_i [2];
  logic [255:0]      midstate_i;
  logic [95:0]       leftovers_i;
  logic [255:0]      target_i;
  logic [31:0]       start_i;
  logic [31:0]       end_i;

  logic              job_ready [2];
  logic [NC-1:0]     req_valid [2];
  logic [NC-1:0]     req_ready [2];
  logic [NC*32-1:0]  req_nonce [2];
  logic [255:0]      c_mid [2];
  logic [95:0]       c_left [2];
  logic [NC-1:0]     res_valid [2];
  logic [NC*256-1:0] res_hash [2];
  logic [NC*32-1:0]  res_nonce [2];
  logic [2:0]        st [2];
  logic [31:0]       cur_n [2];
  logic [31:0]       fnonce [2];
  logic [255:0]      fhash [2];
  logic [15:0]       scount [2];

  logic [31:0]       sol_a [2];
  logic [31:0]       sol_b [2];
  logic [255:0]      sol_hash [2];

  logic              pipe_v [2][NC][8];
  logic [31:0]       pipe_n [2][NC][8];

  int acc_cnt [2];
  int res_cnt [2];
  int zero_cnt [2];
  int bad_req [2];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  multi_core_nonce_scheduler #(.NUM_CORES(NC), .NONCE_W(32), .MAX_OUTST(16), .STOP_ON_FIRST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid[0]), .job_ready(job_ready[0]),
    .midstate(midstate_i), .header_leftovers(leftovers_i), .target(target_i),
    .nonce_start(start_i), .nonce_end(end_i), .abort(abort_i[0]),
    .core_req_valid(req_valid[0]), .core_req_ready(req_ready[0]), .core_nonce(req_nonce[0]),
    .core_midstate(c_mid[0]), .core_leftovers(c_left[0]),
    .core_res_valid(res_valid[0]), .core_res_hash(res_hash[0]), .core_res_nonce(res_nonce[0]),
    .state_out(st[0]), .current_nonce(cur_n[0]), .found_nonce(fnonce[0]),
    .found_hash(fhash[0]), .solutions_count(scount[0]));

  multi_core_nonce_scheduler #(.NUM_CORES(NC), .NONCE_W(32), .MAX_OUTST(16), .STOP_ON_FIRST(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid[1]), .job_ready(job_ready[1]),
    .midstate(midstate_i), .header_leftovers(leftovers_i), .target(target_i),
    .nonce_start(start_i), .nonce_end(end_i), .abort(abort_i[1]),
    .core_req_valid(req_valid[1]), .core_req_ready(req_ready[1]), .core_nonce(req_nonce[1]),
    .core_midstate(c_mid[1]), .core_leftovers(c_left[1]),
    .core_res_valid(res_valid[1]), .core_res_hash(res_hash[1]), .core_res_nonce(res_nonce[1]),
    .state_out(st[1]), .current_nonce(cur_n[1]), .found_nonce(fnonce[1]),
    .found_hash(fhash[1]), .solutions_count(scount[1]));

  // Core model: fixed 8-stage pipeline per core, reset with the scheduler.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        for (int s = 7; s > 0; s--) begin
          pipe_v[d][c][s] <= rst_n & pipe_v[d][c][s-1];
          pipe_n[d][c][s] <= pipe_n[d][c][s-1];
        end
        pipe_v[d][c][0] <= rst_n & req_valid[d][c] & req_ready[d][c];
        pipe_n[d][c][0] <= req_nonce[d][c*32 +: 32];
      end
    end
  end

  // Core model result outputs: matching nonces return sol_hash, others all ones.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      res_valid[d] = {NC{1'b0}};
      res_nonce[d] = {(NC*32){1'b0}};
      res_hash[d]  = {(NC*256){1'b0}};
      for (int c = 0; c < NC; c++) begin
        res_valid[d][c]           = pipe_v[d][c][7];
        res_nonce[d][c*32 +: 32]  = pipe_n[d][c][7];
        res_hash[d][c*256 +: 256] = ((pipe_n[d][c][7] == sol_a[d]) || (pipe_n[d][c][7] == sol_b[d]))
                                    ? sol_hash[d] : ONES;
      end
    end
  end

  function automatic int zero_hits(input logic [NC-1:0] v, input logic [NC*32-1:0] n);
    int k = 0;
    for (int c = 0; c < NC; c++) begin
      if (v[c] && (n[c*32 +: 32] == 32'h0)) k++;
    end
    return k;
  endfunction

  // Traffic monitor: accepted requests, returned results, zero nonces, stray valids.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      acc_cnt[d]  <= acc_cnt[d] + $countones(req_valid[d] & req_ready[d]);
      res_cnt[d]  <= res_cnt[d] + $countones(res_valid[d]);
      zero_cnt[d] <= zero_cnt[d] + zero_hits(req_valid[d] & req_ready[d], req_nonce[d]);
      bad_req[d]  <= bad_req[d] + (((req_valid[d] != {NC{1'b0}}) && (st[d] != 3'd1)) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input int d, input logic [31:0] s, input logic [31:0] e);
    midstate_i   = MID;
    leftovers_i  = LEFT;
    target_i     = TGT;
    start_i      = s;
    end_i        = e;
    job_valid[d] = 1'b1;
    cyc(1);
    job_valid[d] = 1'b0;
  endtask

  task automatic wait_state(input int d, input logic [2:0] exp, input int budget, input string tag);
    int k = 0;
    while ((st[d] !== exp) && (k < budget)) begin
      cyc(1);
      k++;
    end
    chk(tag, {253'd0, st[d]}, {253'd0, exp});
  endtask

  initial begin
    int a0;
    int r0;
    int z0;
    bit seen;
    rst_n       = 1'b0;
    midstate_i  = 256'd0;
    leftovers_i = 96'd0;
    target_i    = 256'd0;
    start_i     = 32'd0;
    end_i       = 32'd0;
    for (int d = 0; d < 2; d++) begin
      job_valid[d] = 1'b0;
      abort_i[d]   = 1'b0;
      req_ready[d] = 4'b1111;
      sol_a[d]     = 32'h9c9a4fc0;
      sol_b[d]     = 32'h9c9a4fc0;
      sol_hash[d]  = TGT;
    end
    #23 rst_n = 1'b1;
    cyc(1);

    // Reset state
    chk("rst_state", {253'd0, st[0]}, 256'd0);
    chk("rst_ready", {255'd0, job_ready[0]}, 256'd1);
    chk("rst_reqv", {252'd0, req_valid[0]}, 256'd0);
    chk("rst_count", {240'd0, scount[0]}, 256'd0);
    chk("rst_fnonce", {224'd0, fnonce[0]}, 256'd0);
    chk("rst_cur", {224'd0, cur_n[0]}, 256'd0);

    // Single nonce, hash == target: counted, FOUND one cycle after the result
    sol_hash[0] = TGT;
    start_job(0, 32'h9c9a4fc0, 32'h9c9a4fc0);
    chk("one_run", {253'd0, st[0]}, 256'd1);
    chk("one_reqv", {252'd0, req_valid[0]}, 256'd1);
    chk("one_mid", c_mid[0], MID);
    chk("one_left", {160'd0, c_left[0]}, {160'd0, LEFT});
    seen = 1'b0;
    for (int k = 0; (k < 30) && !seen; k++) begin
      if (res_valid[0][0]) seen = 1'b1;
      else cyc(1);
    end
    chk("one_res_seen", {255'd0, seen}, 256'd1);
    cyc(1);
    chk("one_found_lat", {253'd0, st[0]}, 256'd2);
    chk("one_count", {240'd0, scount[0]}, 256'd1);

    // Single nonce, hash == target+1: not a solution
    sol_hash[0] = TGT + 256'd1;
    start_job(0, 32'h9c9a4fc0, 32'h9c9a4fc0);
    wait_state(0, 3'd3, 60, "thr_exh");
    chk("thr_count", {240'd0, scount[0]}, 256'd0);
    chk("thr_fnonce", {224'd0, fnonce[0]}, 256'd0);
    sol_hash[0] = TGT;

    // 256-nonce range with one solution
    start_job(0, 32'h9c9a4f00, 32'h9c9a4fff);
    wait_state(0, 3'd2, 400, "r1_found");
    chk("r1_fnonce", {224'd0, fnonce[0]}, 256'h9c9a4fc0);
    chk("r1_fhash", fhash[0], TGT);
    chk("r1_count", {240'd0, scount[0]}, 256'd1);
    chk("r1_drained", acc_cnt[0], res_cnt[0]);
    chk("r1_ready", {255'd0, job_ready[0]}, 256'd1);
    cyc(3);
    chk("r1_hold", {253'd0, st[0]}, 256'd2);
    chk("r1_hold_fn", {224'd0, fnonce[0]}, 256'h9c9a4fc0);

    // Range ending at all-ones: no wrap, exactly 16 requests
    a0 = acc_cnt[0];
    z0 = zero_cnt[0];
    start_job(0, 32'hfffffff0, 32'hffffffff);
    wait_state(0, 3'd3, 200, "top_exh");
    chk("top_reqs", acc_cnt[0] - a0, 256'd16);
    chk("top_zero", zero_cnt[0] - z0, 256'd0);
    chk("top_cur", {224'd0, cur_n[0]}, 256'hffffffff);
    chk("top_drained", acc_cnt[0], res_cnt[0]);

    // Empty range
    a0 = acc_cnt[0];
    start_job(0, 32'd5, 32'd4);
    chk("empty_exh", {253'd0, st[0]}, 256'd3);
    cyc(4);
    chk("empty_reqs", acc_cnt[0] - a0, 256'd0);
    chk("empty_ready", {255'd0, job_ready[0]}, 256'd1);
    chk("empty_hold", {253'd0, st[0]}, 256'd3);

    // Abort with core 2 stalled, then a fresh job
    req_ready[0] = 4'b1011;
    start_job(0, 32'h00001000, 32'h00001fff);
    cyc(20);
    abort_i[0] = 1'b1;
    cyc(1);
    abort_i[0] = 1'b0;
    chk("abort_drain", {253'd0, st[0]}, 256'd4);
    wait_state(0, 3'd0, 40, "abort_idle");
    chk("abort_ready", {255'd0, job_ready[0]}, 256'd1);
    chk("abort_drained", acc_cnt[0], res_cnt[0]);
    req_ready[0] = 4'b1111;
    start_job(0, 32'h9c9a4fc0, 32'h9c9a4fcf);
    wait_state(0, 3'd2, 100, "post_found");
    chk("post_fnonce", {224'd0, fnonce[0]}, 256'h9c9a4fc0);
    chk("post_count", {240'd0, scount[0]}, 256'd1);

    // Full-range mode: two solutions in the same cycle
    r0 = res_cnt[1];
    sol_a[1]    = 32'h00000010;
    sol_b[1]    = 32'h00000013;
    sol_hash[1] = TGT;
    start_job(1, 32'h00000000, 32'h0000003f);
    wait_state(1, 3'd2, 200, "full_found");
    chk("full_count", {240'd0, scount[1]}, 256'd2);
    chk("full_fnonce", {224'd0, fnonce[1]}, 256'h10);
    chk("full_fhash", fhash[1], TGT);
    chk("full_results", res_cnt[1] - r0, 256'd64);
    chk("full_cur", {224'd0, cur_n[1]}, 256'h3f);
    chk("full_ready", {255'd0, job_ready[1]}, 256'd1);

    chk("stray_req0", bad_req[0], 256'd0);
    chk("stray_req1", bad_req[1], 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
